// File: rtl/soc_addr_pkg.sv
// Address map constants for the data-side SoC responder and the byte-strobe
// expansion shared by the RAM bank and the MMIO registers.
package soc_addr_pkg;

    localparam logic [15:0] MMIO_HI    = 16'hBFAF;
    localparam logic [15:0] OFF_TIMER  = 16'hE000;
    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_SEG    = 16'hF010;
    localparam logic [15:0] OFF_SWITCH = 16'hF020;
    localparam logic [15:0] OFF_SIMU   = 16'hFF00;

    function automatic logic [31:0] strobe_to_mask(input logic [3:0] we);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{we[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dsram_bank.sv
// Byte-enabled word RAM with combinational read; kept standalone so a vendor
// distributed-RAM primitive can drop in. The array is intentionally unreset.
module dsram_bank #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];

    // Per-lane byte writes at the clock edge
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_sram_responder.sv
// Data-port responder: decodes each access to either the MMIO register window
// (LED, SEG, SWITCH, TIMER, SIMU flag) or the aliased byte-enabled RAM bank.
module data_sram_responder #(
    parameter int          RAM_AW     = 14,
    parameter logic [15:0] MMIO_HI    = soc_addr_pkg::MMIO_HI,
    parameter bit          SIMULATION = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_i,
    output logic [15:0] led_o,
    output logic [31:0] seg_o,
    output logic [31:0] timer_o
);

    import soc_addr_pkg::*;

    logic              w_mmio_sel;
    logic [15:0]       w_off;
    logic [31:0]       w_mask;
    logic              w_any_we;
    logic              w_wr_timer;
    logic              w_wr_led;
    logic              w_wr_seg;
    logic [3:0]        w_ram_we;
    logic [RAM_AW-1:0] w_ram_addr;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       w_mmio_rdata;
    logic [31:0]       w_led_merged;

    logic [15:0]       r_led;
    logic [31:0]       r_seg;
    logic [31:0]       r_timer;
    logic [7:0]        r_sw_meta;
    logic [7:0]        r_sw_sync;

    assign w_mmio_sel = (data_sram_addr[31:16] == MMIO_HI);
    assign w_off      = data_sram_addr[15:0];
    assign w_mask     = strobe_to_mask(data_sram_we);
    assign w_any_we   = (|data_sram_we) && !reset;
    assign w_wr_timer = w_any_we && w_mmio_sel && (w_off == OFF_TIMER);
    assign w_wr_led   = w_any_we && w_mmio_sel && (w_off == OFF_LED);
    assign w_wr_seg   = w_any_we && w_mmio_sel && (w_off == OFF_SEG);

    assign w_ram_we   = (reset || w_mmio_sel) ? 4'h0 : data_sram_we;
    assign w_ram_addr = data_sram_addr[RAM_AW+1:2];

    assign w_led_merged = ({16'h0000, r_led} & ~w_mask) | (data_sram_wdata & w_mask);

    dsram_bank #(
        .AW(RAM_AW)
    ) u_bank (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(data_sram_wdata),
        .o_rdata(w_ram_rdata)
    );

    // LED and SEG registers with byte-strobe merge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= 16'h0000;
            r_seg <= 32'h0000_0000;
        end else begin
            if (w_wr_led) begin
                r_led <= w_led_merged[15:0];
            end
            if (w_wr_seg) begin
                r_seg <= (r_seg & ~w_mask) | (data_sram_wdata & w_mask);
            end
        end
    end

    // Free-running timer; a write replaces this cycle's increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 32'h0000_0000;
        end else if (w_wr_timer) begin
            r_timer <= (r_timer & ~w_mask) | (data_sram_wdata & w_mask);
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // Two-flop synchronizer for the asynchronous board switches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= switch_i;
            r_sw_sync <= r_sw_meta;
        end
    end

    // MMIO readback mux; unmapped offsets read as zero
    always_comb begin
        w_mmio_rdata = 32'h0000_0000;
        case (w_off)
            OFF_TIMER:  w_mmio_rdata = r_timer;
            OFF_LED:    w_mmio_rdata = {16'h0000, r_led};
            OFF_SEG:    w_mmio_rdata = r_seg;
            OFF_SWITCH: w_mmio_rdata = {24'h00_0000, r_sw_sync};
            OFF_SIMU:   w_mmio_rdata = {32{SIMULATION}};
            default:    w_mmio_rdata = 32'h0000_0000;
        endcase
    end

    assign data_sram_rdata = w_mmio_sel ? w_mmio_rdata : w_ram_rdata;
    assign led_o   = r_led;
    assign seg_o   = r_seg;
    assign timer_o = r_timer;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: a vector table for RAM/MMIO accesses
// plus hand-written sequences for timer, synchronizer, RAW and reset cases.
module tb_data_sram_responder;

    logic        clk;
    logic        reset;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [31:0] seg;
    logic [31:0] timer;

    int n_checks;
    int n_errors;

    data_sram_responder #(
        .RAM_AW    (14),
        .MMIO_HI   (16'hBFAF),
        .SIMULATION(1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_sram_we   (we),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata),
        .switch_i       (sw),
        .led_o          (led),
        .seg_o          (seg),
        .timer_o        (timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
        logic [31:0] exp_seg;
    } vec_t;

    vec_t vecs [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        we    = w;
        addr  = a;
        wdata = d;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        we    = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        sw    = 8'h00;

        //            we     addr           wdata         chk   exp_rd         led       seg
        vecs[0]  = '{4'hF, 32'h1C000100, 32'hDEADBEEF, 1'b0, 32'h0,         16'h0000, 32'h0};
        vecs[1]  = '{4'h2, 32'h1C000100, 32'h00005500, 1'b1, 32'hDEADBEEF,  16'h0000, 32'h0};
        vecs[2]  = '{4'h0, 32'h1C000100, 32'h0,        1'b1, 32'hDEAD55EF,  16'h0000, 32'h0};
        vecs[3]  = '{4'h0, 32'h1C010100, 32'h0,        1'b1, 32'hDEAD55EF,  16'h0000, 32'h0};
        vecs[4]  = '{4'h3, 32'hBFAFF000, 32'h1234ABCD, 1'b1, 32'h0,         16'h0000, 32'h0};
        vecs[5]  = '{4'h0, 32'hBFAFF000, 32'h0,        1'b1, 32'h0000ABCD,  16'hABCD, 32'h0};
        vecs[6]  = '{4'hF, 32'hBFAFF010, 32'hCAFEF00D, 1'b1, 32'h0,         16'hABCD, 32'h0};
        vecs[7]  = '{4'h0, 32'hBFAFF010, 32'h0,        1'b1, 32'hCAFEF00D,  16'hABCD, 32'hCAFEF00D};
        vecs[8]  = '{4'h4, 32'hBFAFF010, 32'h00770000, 1'b1, 32'hCAFEF00D,  16'hABCD, 32'hCAFEF00D};
        vecs[9]  = '{4'h0, 32'hBFAFF010, 32'h0,        1'b1, 32'hCA77F00D,  16'hABCD, 32'hCA77F00D};
        vecs[10] = '{4'hF, 32'hBFAFF0F0, 32'hFFFFFFFF, 1'b1, 32'h0,         16'hABCD, 32'hCA77F00D};
        vecs[11] = '{4'h0, 32'hBFAFF0F0, 32'h0,        1'b1, 32'h0,         16'hABCD, 32'hCA77F00D};
        vecs[12] = '{4'h0, 32'hBFAFF000, 32'h0,        1'b1, 32'h0000ABCD,  16'hABCD, 32'hCA77F00D};
        vecs[13] = '{4'h0, 32'hBFAFFF00, 32'h0,        1'b1, 32'hFFFFFFFF,  16'hABCD, 32'hCA77F00D};
        vecs[14] = '{4'hF, 32'hBFAFFF00, 32'h0,        1'b1, 32'hFFFFFFFF,  16'hABCD, 32'hCA77F00D};
        vecs[15] = '{4'h0, 32'hBFAFFF00, 32'h0,        1'b1, 32'hFFFFFFFF,  16'hABCD, 32'hCA77F00D};
        vecs[16] = '{4'hF, 32'hBFAFF020, 32'h000000FF, 1'b1, 32'h0,         16'hABCD, 32'hCA77F00D};
        vecs[17] = '{4'h0, 32'hBFAFF020, 32'h0,        1'b1, 32'h0,         16'hABCD, 32'hCA77F00D};
        vecs[18] = '{4'hF, 32'h1C010104, 32'h12345678, 1'b0, 32'h0,         16'hABCD, 32'hCA77F00D};
        vecs[19] = '{4'h0, 32'h1C000104, 32'h0,        1'b1, 32'h12345678,  16'hABCD, 32'hCA77F00D};

        // Reset state and timer start-up
        tick(); tick(); tick();
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_seg", seg, 32'h0);
        check("rst_timer", timer, 32'h0);
        reset = 1'b0;
        drive(4'h0, 32'hBFAFE000, 32'h0);
        check("timer_t0", rdata, 32'h0);
        tick();
        check("timer_t1", rdata, 32'h1);
        tick();
        check("timer_t2", rdata, 32'h2);
        tick();

        // Vector table: one access per cycle
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
            check($sformatf("vec%0d_seg", i), seg, vecs[i].exp_seg);
            tick();
        end

        // Timer load and wrap
        drive(4'hF, 32'hBFAFE000, 32'hFFFFFFFE);
        tick();
        drive(4'h0, 32'hBFAFE000, 32'h0);
        check("timer_ld", rdata, 32'hFFFFFFFE);
        tick();
        check("timer_max", rdata, 32'hFFFFFFFF);
        tick();
        check("timer_wrap", rdata, 32'h0);
        check("timer_o_wrap", timer, 32'h0);

        // Partial-strobe timer write keeps un-strobed bytes of the old value
        drive(4'hF, 32'hBFAFE000, 32'h00000100);
        tick();
        check("timer_100", timer, 32'h100);
        drive(4'h1, 32'hBFAFE000, 32'h000000AA);
        tick();
        drive(4'h0, 32'hBFAFE000, 32'h0);
        check("timer_part", rdata, 32'h1AA);

        // Switch synchronizer: two edges to reach readback
        drive(4'h0, 32'hBFAFF020, 32'h0);
        sw = 8'h5A;
        #1;
        check("sw_e0", rdata, 32'h0);
        tick();
        check("sw_e1", rdata, 32'h0);
        tick();
        check("sw_e2", rdata, 32'h5A);

        // Same-cycle read-after-write returns old data
        drive(4'hF, 32'h1C000200, 32'h00000055);
        tick();
        drive(4'hF, 32'h1C000200, 32'h00000011);
        check("raw_old", rdata, 32'h55);
        tick();
        drive(4'h0, 32'h1C000200, 32'h0);
        check("raw_new", rdata, 32'h11);

        // Reset mid-run blocks writes and clears registers
        drive(4'h3, 32'hBFAFF000, 32'h0000FFFF);
        tick();
        check("led_ffff", {16'h0, led}, 32'h0000FFFF);
        reset = 1'b1;
        drive(4'hF, 32'h1C000200, 32'h00000BAD);
        tick();
        drive(4'h0, 32'h1C000200, 32'h0);
        check("mrst_led", {16'h0, led}, 32'h0);
        check("mrst_timer", timer, 32'h0);
        check("mrst_ram", rdata, 32'h11);
        drive(4'h0, 32'hBFAFF020, 32'h0);
        check("mrst_sw", rdata, 32'h0);
        reset = 1'b0;
        drive(4'h0, 32'h1C000200, 32'h0);
        tick();
        check("post_rst_ram", rdata, 32'h11);
        check("post_rst_timer", timer, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
